// File: rtl/attn_pkg.sv
// Shared types and Q-format constants for the attention blocks, plus the
// elaboration-time exp() used to build the exp lookup table.
package attn_pkg;

    typedef enum logic [1:0] {
        ACC,
        EXP,
        DIV,
        OUT
    } state_t;

    // Score x is signed Q1.6, e is UQ3.6, weights are UQ0.8.
    localparam int X_W    = 8;
    localparam int X_FRAC = 6;
    localparam int X_MAX  = 127;
    localparam int X_MIN  = -128;
    localparam int E_W    = 9;
    localparam int E_FRAC = 6;
    localparam int W_W    = 8;

    localparam int                   DIV_NUM_W = 17;
    localparam logic [DIV_NUM_W-1:0] DIV_NUM   = 17'd65536;
    localparam int                   DIV_CYC   = DIV_NUM_W;

    localparam int EXP_CALC_F = 40;

    // round(2^E_FRAC * exp(x / 2^X_FRAC)) by Taylor series in 40-bit fixed point;
    // only ever evaluated on constants, so it folds away at elaboration.
    function automatic logic [E_W-1:0] exp_q6(input int x);
        longint one;
        longint term;
        longint sum;
        one  = longint'(1) <<< EXP_CALC_F;
        term = one;
        sum  = one;
        for (int n = 1; n < 32; n++) begin
            term = (term * longint'(x)) / longint'(n << X_FRAC);
            sum  = sum + term;
        end
        return E_W'(((sum <<< E_FRAC) + (one >>> 1)) >>> EXP_CALC_F);
    endfunction

endpackage

// File: rtl/attn_exp.sv
// Combinational exp table: signed Q1.6 score in, UQ3.6 round(64*exp(x/64)) out.
// Table contents are constants computed at elaboration.
module attn_exp
    import attn_pkg::*;
(
    input  logic signed [X_W-1:0] x,
    output logic        [E_W-1:0] e
);

    logic [E_W-1:0] lut [2**X_W];

    for (genvar i = 0; i < 2**X_W; i++) begin : g_lut
        localparam logic [E_W-1:0] ENTRY = exp_q6(i - 2**(X_W-1));
        assign lut[i] = ENTRY;
    end

    // Offset-binary index: entry 0 holds x = -128.
    assign e = lut[{~x[X_W-1], x[X_W-2:0]}];

endmodule

// File: rtl/attn_softmax_stream.sv
// Streaming softmax over attention scores: dot-product accumulate, exp table,
// reciprocal of the row sum, weighted output. ATTN_MAXSUB_EN adds max subtraction.
module attn_softmax_stream
    import attn_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FEAT_DIM    = 4,
    parameter int SEQ_LEN     = 4,
    parameter int SCORE_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] s_q,
    input  logic signed [DATA_W-1:0] s_k,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic        [W_W-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam int PROD_W  = 2 * DATA_W;
    localparam int ACC_W   = PROD_W + $clog2(FEAT_DIM);
    localparam int BEAT_W  = $clog2(FEAT_DIM);
    localparam int IDX_W   = $clog2(SEQ_LEN);
    localparam int Z_W     = E_W + IDX_W;
    localparam int X_SHIFT = PROD_W - X_W + SCORE_SHIFT;
    localparam int WP_W    = E_W + DIV_NUM_W;
    localparam int DC_W    = $clog2(DIV_CYC);

    localparam logic signed [ACC_W-1:0] ACC_X_HI = ACC_W'(X_MAX);
    localparam logic signed [ACC_W-1:0] ACC_X_LO = ACC_W'(X_MIN);
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(SEQ_LEN - 1);

    state_t state, state_nxt;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc, acc_sum, acc_sh;
    logic signed [X_W-1:0]    x_sat, exp_in;
    logic        [E_W-1:0]    e_val;
    logic        [BEAT_W-1:0] beat;
    logic        [IDX_W-1:0]  idx, w_sel;
    logic        [Z_W-1:0]    z, rem, rem_sub, rem_nxt;
    logic        [Z_W:0]      rem_sh;
    logic        [DIV_NUM_W-1:0] quot, quot_nxt;
    logic        [DC_W-1:0]   div_cnt;
    logic        [WP_W-9:0]   w_shr;
    logic        [W_W-1:0]    w_sat;
    logic s_fire, m_fire, beat_last, idx_last, div_last, div_ge;

    logic [E_W-1:0] ebuf [SEQ_LEN];

    assign s_ready   = (state == ACC);
    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign beat_last = (beat == BEAT_W'(FEAT_DIM - 1));
    assign idx_last  = (idx == IDX_LAST);
    assign div_last  = (div_cnt == DC_W'(DIV_CYC - 1));

    assign prod    = PROD_W'(s_q) * PROD_W'(s_k);
    assign acc_sum = acc + ACC_W'(prod);
    assign acc_sh  = acc_sum >>> X_SHIFT;

    always_comb begin
        if (acc_sh > ACC_X_HI)
            x_sat = X_W'(X_MAX);
        else if (acc_sh < ACC_X_LO)
            x_sat = X_W'(X_MIN);
        else
            x_sat = acc_sh[X_W-1:0];
    end

`ifdef ATTN_MAXSUB_EN
    logic signed [X_W-1:0] max_x, x_raw;
    logic signed [X_W:0]   x_rel;

    assign x_raw = ebuf[idx][X_W-1:0];
    assign x_rel = {x_raw[X_W-1], x_raw} - {max_x[X_W-1], max_x};

    always_comb begin
        if (x_rel < (X_W+1)'(X_MIN))
            exp_in = X_W'(X_MIN);
        else if (x_rel > (X_W+1)'(X_MAX))
            exp_in = X_W'(X_MAX);
        else
            exp_in = x_rel[X_W-1:0];
    end
`else
    assign exp_in = x_sat;
`endif

    attn_exp u_exp (
        .x (exp_in),
        .e (e_val)
    );

    // Restoring divider: quot starts as the numerator and shifts into the remainder.
    assign rem_sh   = {rem, quot[DIV_NUM_W-1]};
    assign div_ge   = (rem_sh >= {1'b0, z});
    assign rem_sub  = Z_W'(rem_sh - {1'b0, z});
    assign rem_nxt  = div_ge ? rem_sub : rem_sh[Z_W-1:0];
    assign quot_nxt = {quot[DIV_NUM_W-2:0], div_ge};

    assign w_sel = m_valid ? idx + IDX_W'(1) : idx;
    assign w_shr = (WP_W-8)'((WP_W'(ebuf[w_sel]) * WP_W'(quot)) >> 8);
    assign w_sat = (|w_shr[WP_W-9:W_W]) ? '1 : w_shr[W_W-1:0];

    // NOTE: always_comb assigns every output a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACC: if (s_valid && beat_last && idx_last) state_nxt = EXP;
`ifdef ATTN_MAXSUB_EN
            EXP: if (idx_last) state_nxt = DIV;
`else
            EXP: state_nxt = DIV;
`endif
            DIV: if (div_last) state_nxt = OUT;
            OUT: if (m_fire && m_last) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ACC;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            beat    <= '0;
            idx     <= '0;
            z       <= '0;
            rem     <= '0;
            quot    <= '0;
            div_cnt <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
`ifdef ATTN_MAXSUB_EN
            max_x   <= '0;
`endif
        end else begin
            unique case (state)
                ACC: begin
                    if (s_fire) begin
                        beat <= beat + BEAT_W'(1);
                        if (beat_last) begin
                            acc <= '0;
                            idx <= idx + IDX_W'(1);
`ifdef ATTN_MAXSUB_EN
                            if (idx == '0 || x_sat > max_x)
                                max_x <= x_sat;
`else
                            z <= z + Z_W'(e_val);
`endif
                        end else begin
                            acc <= acc_sum;
                        end
                    end
                end
                EXP: begin
`ifdef ATTN_MAXSUB_EN
                    z   <= z + Z_W'(e_val);
                    idx <= idx + IDX_W'(1);
`endif
                    rem     <= '0;
                    quot    <= DIV_NUM;
                    div_cnt <= '0;
                end
                DIV: begin
                    rem     <= rem_nxt;
                    div_cnt <= div_cnt + DC_W'(1);
                    if (div_last && z == '0)
                        quot <= '0;
                    else
                        quot <= quot_nxt;
                end
                OUT: begin
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= w_sat;
                        m_last  <= (w_sel == IDX_LAST);
                    end else if (m_ready) begin
                        if (m_last) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_data  <= '0;
                            idx     <= '0;
                            z       <= '0;
                        end else begin
                            idx    <= w_sel;
                            m_data <= w_sat;
                            m_last <= (w_sel == IDX_LAST);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the score buffer has no reset; every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (s_fire && beat_last) begin
`ifdef ATTN_MAXSUB_EN
            ebuf[idx] <= E_W'(x_sat);
`else
            ebuf[idx] <= e_val;
`endif
        end
`ifdef ATTN_MAXSUB_EN
        else if (state == EXP) begin
            ebuf[idx] <= e_val;
        end
`endif
    end

endmodule

// File: tb/tb_attn_softmax_stream.sv
// Directed bench for attn_softmax_stream: hand-computed rows, latency,
// backpressure and mid-row reset, checked with immediate assertions.
module tb_attn_softmax_stream;

`ifdef ATTN_MAXSUB_EN
    localparam int LAT    = 23;
    localparam int W_BIG  = 180;
    localparam int W_X100 = 64;
`else
    localparam int LAT    = 20;
    localparam int W_BIG  = 178;
    localparam int W_X100 = 63;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_q, s_k;
    logic       s_valid, s_ready;
    logic [7:0] m_data;
    logic       m_valid, m_ready, m_last;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] bq [16];
    logic [7:0] bk [16];
    int         exp_w [4];

    always #5 clk = ~clk;

    attn_softmax_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_q     (s_q),
        .s_k     (s_k),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_row();
        for (int i = 0; i < 16; i++) begin
            bq[i] = 8'h00;
            bk[i] = 8'h00;
        end
    endtask

    task automatic set_score(input int s, input logic [7:0] q, input logic [7:0] k);
        for (int b = 0; b < 4; b++) begin
            bq[s*4+b] = q;
            bk[s*4+b] = k;
        end
    endtask

    task automatic set_exp(input int w0, input int w1, input int w2, input int w3);
        exp_w[0] = w0;
        exp_w[1] = w1;
        exp_w[2] = w2;
        exp_w[3] = w3;
    endtask

    // Called and returns at a falling edge.
    task automatic send_beat(input logic [7:0] q, input logic [7:0] k);
        int t;
        t = 0;
        s_q = q;
        s_k = k;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t == 100) check("s_ready_timeout", {31'd0, s_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_row();
        int lat;
        for (int i = 0; i < 16; i++) send_beat(bq[i], bk[i]);
        lat = 1;
        while (m_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, LAT);
    endtask

    task automatic recv_row(input int stall_idx);
        int t;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (m_valid !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("m_valid_w%0d", i), {31'd0, m_valid}, 32'd1);
            if (i == stall_idx) begin
                m_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(posedge clk);
                    @(negedge clk);
                    check("stall_data", {24'd0, m_data}, exp_w[i]);
                    check("stall_valid", {31'd0, m_valid}, 32'd1);
                end
                m_ready = 1'b1;
            end
            check($sformatf("w%0d", i), {24'd0, m_data}, exp_w[i]);
            check($sformatf("last_w%0d", i), {31'd0, m_last}, (i == 3) ? 32'd1 : 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("s_ready_after_row", {31'd0, s_ready}, 32'd1);
        check("m_valid_after_row", {31'd0, m_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        s_q = 8'h00;
        s_k = 8'h00;
        s_valid = 1'b0;
        m_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_last", {31'd0, m_last}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd1);

        // All zero: e=64 each, Z=256, R=256
        clear_row();
        set_exp(64, 64, 64, 64);
        send_row();
        recv_row(-1);

        // Score 0 saturating positive: x0=126
        clear_row();
        set_score(0, 8'h7F, 8'h7F);
        set_exp(W_BIG, 25, 25, 25);
        send_row();
        recv_row(-1);

        // Score 0 most negative: x0=-127, e0=9, Z=201, R=326
        clear_row();
        set_score(0, 8'h80, 8'h7F);
        set_exp(11, 81, 81, 81);
        send_row();
        recv_row(-1);

        // Big score at index 2, stalled while weight 2 is presented
        clear_row();
        set_score(2, 8'h7F, 8'h7F);
        set_exp(25, 25, W_BIG, 25);
        send_row();
        recv_row(2);

        // Every score x=100
        clear_row();
        for (int s = 0; s < 4; s++) begin
            set_score(s, 8'h7F, 8'h7F);
            bk[s*4+3] = 8'd23;
        end
        set_exp(W_X100, W_X100, W_X100, W_X100);
        send_row();
        recv_row(-1);

        // Reset after 9 beats discards the partial row
        for (int i = 0; i < 9; i++) send_beat(8'h7F, 8'h7F);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_m_last", {31'd0, m_last}, 32'd0);
        check("midrst_m_data", {24'd0, m_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_s_ready", {31'd0, s_ready}, 32'd1);
        clear_row();
        set_exp(64, 64, 64, 64);
        send_row();
        recv_row(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
